// File: rtl/my_ram_pkg.sv
// Shared definitions for the my_ram_64 burst read path.
// Contents:
//   ADDR_W  - RAM address width (64 words)
//   DATA_W  - RAM word width
//   state_t - burst reader FSM states (IDLE, FETCH, SEND)
package my_ram_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2
    } state_t;

endpackage : my_ram_pkg

// File: rtl/my_ram_64.sv
// 64-word x 16-bit RAM: combinational read, write on rising clock edge.
// Ports:
//   clk  - clock
//   addr - word address
//   load - write enable
//   in   - write data
//   out  - read data, combinational from addr
module my_ram_64 (
    input  logic        clk,
    input  logic [5:0]  addr,
    input  logic        load,
    input  logic [15:0] in,
    output logic [15:0] out
);

    logic [15:0] r_mem [64];

    always_ff @(posedge clk) begin
        if (load) begin
            r_mem[addr] <= in;
        end
    end

    assign out = r_mem[addr];

endmodule : my_ram_64

// File: rtl/my_ram_64_burst_reader.sv
// Read-side burst initiator for my_ram_64.
// Accepts (start address, length-1) on a valid/ready command channel, then
// walks consecutive RAM addresses (wrapping 63 -> 0) and streams each word on
// a valid/ready output channel, flagging the final word with out_last.
//
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   cmd_valid/cmd_ready - command handshake; cmd_addr = first word,
//                         cmd_len = words-1
//   out_valid/out_ready - data handshake; out_data = word, out_last = final
//   ram_addr/ram_load/ram_in/ram_out - RAM port (read-only use)
//
// Optional build macro MY_RAM_BURST_CHECKSUM_EN adds burst_sum (mod 2^16 sum
// of the words handed off in the burst) and sum_valid (one-cycle pulse after
// the final handshake).
module my_ram_64_burst_reader #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
`ifdef MY_RAM_BURST_CHECKSUM_EN
    output logic [DATA_W-1:0] burst_sum,
    output logic              sum_valid,
`endif
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_load,
    output logic [DATA_W-1:0] ram_in,
    input  logic [DATA_W-1:0] ram_out
);

    import my_ram_pkg::*;

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_addr_q;
    logic [ADDR_W-1:0] r_rem_q;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_last;
    logic              w_accept;
    logic              w_handshake;

    assign cmd_ready   = (r_state == IDLE) && !reset;
    assign w_accept    = cmd_valid && cmd_ready;
    assign w_handshake = (r_state == SEND) && out_ready;

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;

    // The RAM is always addressed by the walking counter; its combinational
    // output is sampled in FETCH and on every non-final handshake in SEND.
    assign ram_addr = r_addr_q;
    assign ram_load = 1'b0;
    assign ram_in   = '0;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = FETCH;
            FETCH:   w_state_next = SEND;
            SEND:    if (out_ready && r_out_last) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_addr_q    <= '0;
            r_rem_q     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_addr_q <= cmd_addr;
                        r_rem_q  <= cmd_len;
                    end
                end
                FETCH: begin
                    r_out_data  <= ram_out;
                    r_out_last  <= (r_rem_q == '0);
                    r_out_valid <= 1'b1;
                    r_addr_q    <= r_addr_q + 1'b1;
                end
                SEND: begin
                    if (out_ready) begin
                        if (!r_out_last) begin
                            // Prefetch the next word so one word moves per cycle.
                            // rem_q == 1 here means the word being loaded is the last.
                            r_out_data <= ram_out;
                            r_addr_q   <= r_addr_q + 1'b1;
                            r_rem_q    <= r_rem_q - 1'b1;
                            r_out_last <= (r_rem_q == ADDR_W'(1));
                        end else begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MY_RAM_BURST_CHECKSUM_EN
    logic [DATA_W-1:0] r_burst_sum;
    logic              r_sum_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_burst_sum <= '0;
            r_sum_valid <= 1'b0;
        end else begin
            r_sum_valid <= 1'b0;
            if (w_accept) begin
                r_burst_sum <= '0;
            end else if (w_handshake) begin
                r_burst_sum <= r_burst_sum + r_out_data;
                r_sum_valid <= r_out_last;
            end
        end
    end

    assign burst_sum = r_burst_sum;
    assign sum_valid = r_sum_valid;
`else
    logic w_unused;
    assign w_unused = w_handshake;
`endif

endmodule : my_ram_64_burst_reader

// File: doc/my_ram_64_burst_reader.md
Name: my_ram_64_burst_reader

Overview:
Read-side initiator for the 64-word, 16-bit RAM port (addr[5:0], load, in[15:0], out[15:0], combinational read, write on clk rising edge).
- Accepts a burst command (start address, length) over a valid/ready handshake.
- Walks consecutive RAM addresses and streams each word out on a valid/ready data channel, flagging the last word.
- Sits between my_ram_64 and any consumer needing sequential block reads (loader, display scan, dump).

Parameters:
ADDR_W, 6, RAM address width; 64 words.
DATA_W, 16, RAM word width.

Ports:
clk  input  1  single clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
cmd_valid  input  1  burst command present.
cmd_ready  output  1  block can accept a command.
cmd_addr  input  ADDR_W  first word address.
cmd_len  input  ADDR_W  burst length minus one; 0 means 1 word, 63 means 64 words.
out_valid  output  1  out_data holds a word.
out_ready  input  1  consumer takes the word.
out_data  output  DATA_W  word read from RAM.
out_last  output  1  current word is the final word of the burst.
ram_addr  output  ADDR_W  address to RAM.
ram_load  output  1  RAM write enable; tied 0.
ram_in  output  DATA_W  RAM write data; tied 0.
ram_out  input  DATA_W  RAM combinational read data.

Behaviour:
- Reset (sync, reset high at edge):
  - state=IDLE, out_valid=0, out_data=0, out_last=0.
  - addr_q=0, rem_q=0, ram_addr=0.
- cmd_ready = (state==IDLE) && !reset.
- ram_addr = addr_q in all states.
- IDLE:
  - On cmd_valid && cmd_ready at an edge: addr_q<=cmd_addr, rem_q<=cmd_len, go to FETCH.
  - Command fields are sampled only at that edge.
- FETCH (one cycle):
  - out_data<=ram_out, out_last<=(rem_q==0), out_valid<=1.
  - addr_q<=addr_q+1 (mod 64), go to SEND.
- SEND:
  - out_valid=1; out_data and out_last held stable while out_ready=0.
  - out_ready && !out_last: out_data<=ram_out (next word at addr_q), addr_q<=addr_q+1, rem_q<=rem_q-1, out_last<=(rem_q==1). Stay in SEND; 1 word per cycle.
  - out_ready && out_last: out_valid<=0, out_last<=0, go to IDLE.
- Latency: command accept at edge N gives out_valid=1 from edge N+1 (after the FETCH cycle).
- Next command is accepted no earlier than the cycle after the last handshake.
- Address wrap: 63+1 -> 0. A burst of 64 starting at address 5 reads 5..63 then 0..4.
- cmd_valid outside IDLE is ignored; the command is not queued.
- RAM contents changed by another writer mid-burst: the word returned is whatever ram_out shows at the sampling edge.
- Reset mid-burst: burst aborted, no out_last issued, outputs return to reset values at that edge.
- Arithmetic: addr_q is ADDR_W bits with natural wrap. rem_q never underflows because last is detected first.

Optional Feature:
MY_RAM_BURST_CHECKSUM_EN
- Defined:
  - Adds output burst_sum[DATA_W] and output sum_valid[1].
  - burst_sum is the mod-2^16 sum of all words handed off in the burst; cleared on command accept.
  - sum_valid pulses 1 for one cycle on the edge after the out_last handshake.
  - Both are 0 after reset and on abort.
- Undefined: neither port exists; no adder logic.

Decomposition:
- Package my_ram_pkg:
  - ADDR_W=6, DATA_W=16.
  - State enum {IDLE, FETCH, SEND}.
- No sub-module; the FSM, address counter and remaining counter fit in one module.
- Bench instantiates my_ram_64 and muxes its port between a preload driver and this block.

Test Plan:
- Single word: preload mem[0]=2, cmd addr=0 len=0 with out_ready=1 -> one word 2 with out_last=1; cmd_ready returns 1 the next cycle.
- Burst: preload mem[k]=k+2 for k=0..7, cmd addr=0 len=7, out_ready=1 -> words 2..9 on consecutive cycles; out_last only on 9; 8 handshakes total.
- Backpressure: same burst, out_ready=0 on every other cycle -> each word held stable while stalled; sequence still 2..9, no duplicates or drops.
- Wrap: preload mem[62]=100, mem[63]=101, mem[0]=102, cmd addr=62 len=2 -> 100, 101, 102 with last on 102.
- Reset mid-burst: assert reset after 3rd word of 8-word burst -> next edge out_valid=0, out_last=0; new cmd addr=19 len=0 (mem[19]=5) -> 5 with last.
- Checksum (macro defined): burst of 2..9 -> sum_valid pulse with burst_sum=44, one cycle after the last handshake.
